// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences the 8-bit core through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and counts retirements.
// Latency: 2 (JMP/NOP) to 5 (LOAD) cycles per instruction plus memory wait cycles; outputs are combinational from state.
// Backpressure: mem_ready low holds FETCH/MEM with the request asserted. Optional macro ILLEGAL_TRAP_EN adds TRAP + illegal_op.
module multicycle_control_unit #(
  parameter int OPCODE_W  = 4,
  parameter int ALU_SEL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  Opcode,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemToReg,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_TRAP
  } state_t;

  // Instruction classes; the ALU class carries its ALU code in opcode bits [2:0].
  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STORE, K_BEQ, K_JMP, K_NOP, K_HALT, K_ILL
  } kind_t;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = ALU_SEL_W'(3'b001);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OPCODE_W-1:0]  r_op_q;
  logic [CNT_W-1:0]     r_instr_count;
  kind_t                w_dec_kind;
  kind_t                w_op_kind;
  logic                 w_retire;

  // Any set bit above [3:0] makes the opcode illegal regardless of the low nibble.
  function automatic kind_t classify(input logic [OPCODE_W-1:0] op);
    logic [OPCODE_W-1:0] hi;
    kind_t               k;
    hi = op >> 4;
    if (hi != '0) begin
      k = K_ILL;
    end else begin
      case (op[3:0])
        4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: k = K_ALU;
        4'b1000: k = K_LOAD;
        4'b1001: k = K_STORE;
        4'b1010: k = K_BEQ;
        4'b1011: k = K_JMP;
        4'b1110: k = K_NOP;
        4'b1111: k = K_HALT;
        default: k = K_ILL;
      endcase
    end
    return k;
  endfunction

  // DECODE looks at the live opcode; every later state works from the captured copy.
  assign w_dec_kind = classify(Opcode);
  assign w_op_kind  = classify(r_op_q);

  // Next-state and datapath enables; everything defaults to idle so unused states drive zeros.
  always_comb begin
    w_state_nxt = r_state;
    ALU_Sel     = '0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite     = 1'b1;
          PCWrite     = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_dec_kind)
          K_ALU, K_LOAD, K_STORE, K_BEQ: w_state_nxt = S_EXECUTE;
          K_JMP: begin
            PCWrite     = 1'b1;
            PCSrc       = 1'b1;
            w_state_nxt = S_FETCH;
          end
          K_HALT: w_state_nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          K_ILL: w_state_nxt = S_TRAP;
`endif
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_EXECUTE: begin
        case (w_op_kind)
          K_LOAD, K_STORE: begin
            ALU_Sel     = ALU_ADD;
            w_state_nxt = S_MEM;
          end
          K_BEQ: begin
            ALU_Sel     = ALU_SUB;
            PCWrite     = Zero;
            PCSrc       = Zero;
            w_state_nxt = S_FETCH;
          end
          default: begin
            ALU_Sel     = ALU_SEL_W'(r_op_q[2:0]);
            w_state_nxt = S_WRITEBACK;
          end
        endcase
      end
      S_MEM: begin
        if (w_op_kind == K_LOAD) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
        end
        if (mem_ready) begin
          w_state_nxt = (w_op_kind == K_LOAD) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        RegWrite    = 1'b1;
        MemToReg    = (w_op_kind == K_LOAD);
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // An instruction retires when it hands control back to FETCH or enters HALT.
  always_comb begin
    w_retire = 1'b0;
    if (w_state_nxt == S_FETCH &&
        (r_state == S_DECODE || r_state == S_EXECUTE ||
         r_state == S_MEM    || r_state == S_WRITEBACK)) begin
      w_retire = 1'b1;
    end
    if (w_state_nxt == S_HALT && r_state != S_HALT) begin
      w_retire = 1'b1;
    end
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the opcode while it is being decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_q <= '0;
    end else if (r_state == S_DECODE) begin
      r_op_q <= Opcode;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign instr_count = r_instr_count;

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal_op;

  // Sticky flag raised on TRAP entry; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal_op <= 1'b0;
    end else if (w_state_nxt == S_TRAP && r_state != S_TRAP) begin
      r_illegal_op <= 1'b1;
    end
  end

  assign illegal_op = r_illegal_op;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of single instructions, hand-written multi-cycle corners, random program.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  Opcode = 4'h0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  ALU_Sel;
  logic        RegWrite, MemRead, MemWrite, MemToReg, IRWrite, PCWrite, PCSrc, halted;
  logic [15:0] instr_count;
  logic [2:0]  d4_alu;
  logic        d4_rw, d4_mr, d4_mw, d4_m2r, d4_irw, d4_pcw, d4_pcs, d4_hlt;
  logic [3:0]  d4_count;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_op, d4_illegal_op;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit u_dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .ALU_Sel(ALU_Sel), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .halted(halted), .instr_count(instr_count)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  // Narrow-counter copy sharing all inputs, used to observe wrap-around.
  multicycle_control_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .ALU_Sel(d4_alu), .RegWrite(d4_rw), .MemRead(d4_mr), .MemWrite(d4_mw),
    .MemToReg(d4_m2r), .IRWrite(d4_irw), .PCWrite(d4_pcw), .PCSrc(d4_pcs),
    .halted(d4_hlt), .instr_count(d4_count)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(d4_illegal_op)
`endif
  );

  localparam int KA = 0, KL = 1, KS = 2, KB = 3, KJ = 4, KN = 5, KH = 6, KI = 7;

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         len;
    logic [2:0] alu;
    logic       pcs;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned m_count = 0;
  logic        m_ill = 1'b0;
  int          t_len, t_mcyc;
  logic [2:0]  t_alu;
  logic        t_pcs;

  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: return KA;
      4'h8: return KL;
      4'h9: return KS;
      4'hA: return KB;
      4'hB: return KJ;
      4'hE: return KN;
      4'hF: return KH;
      default: return KI;
    endcase
  endfunction

  function automatic logic [10:0] ev(input logic [2:0] alu, input logic rw, input logic mr,
                                     input logic mw, input logic m2r, input logic irw,
                                     input logic pcw, input logic pcs, input logic hlt);
    return {alu, rw, mr, mw, m2r, irw, pcw, pcs, hlt};
  endfunction

  function automatic logic [10:0] outs();
    return {ALU_Sel, RegWrite, MemRead, MemWrite, MemToReg, IRWrite, PCWrite, PCSrc, halted};
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, then advance to the next rising edge.
  task automatic step(input string nm, input logic [3:0] opc, input logic rdy, input logic z,
                      input logic [10:0] exp);
    logic [10:0] g;
    @(negedge clk);
    Opcode = opc; mem_ready = rdy; Zero = z;
    #1;
    g = outs();
    chk({nm, " outs"}, 32'(g), 32'(exp));
    chk({nm, " count"}, 32'(instr_count), 32'(m_count[15:0]));
`ifdef ILLEGAL_TRAP_EN
    chk({nm, " illegal_op"}, 32'(illegal_op), 32'(m_ill));
`endif
    t_len++;
    t_alu = t_alu | g[10:8];
    t_pcs = t_pcs | g[1];
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = rbit(); Zero = rbit(); Opcode = 4'($urandom);
    #1;
    m_count = 0; m_ill = 1'b0;
    chk("reset outs", 32'(outs()), 32'd0);
    chk("reset count", 32'(instr_count), 32'd0);
    chk("reset count4", 32'(d4_count), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("reset illegal_op", 32'(illegal_op), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle outs", 32'(outs()), 32'd0);
    @(posedge clk);
  endtask

  // Reference for one instruction, expressed as its sequence of memory and datapath steps.
  // fwait/mwait: ready-low cycles before the fetch/memory access completes; negative means random.
  task automatic run_instr(input logic [3:0] op, input logic z, input int fwait, input int mwait);
    int   k, w;
    logic rdy, isl;
    t_len = 0; t_mcyc = 0; t_alu = 3'd0; t_pcs = 1'b0;
    k = kind_of(op);
    w = 0;
    do begin
      rdy = (fwait < 0) ? (w >= 20 || $urandom_range(0, 2) != 0) : (w >= fwait);
      step("fetch", 4'($urandom), rdy, rbit(), ev(3'd0, 0, 1, 0, 0, rdy, rdy, 0, 0));
      w++;
    end while (!rdy);
    step("decode", op, rbit(), rbit(), ev(3'd0, 0, 0, 0, 0, 0, k == KJ, k == KJ, 0));
    if (k == KA) begin
      step("exec alu", 4'($urandom), rbit(), rbit(), ev(op[2:0], 0, 0, 0, 0, 0, 0, 0, 0));
      step("wb alu", 4'($urandom), rbit(), rbit(), ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
      m_count++;
    end else if (k == KB) begin
      step("exec beq", 4'($urandom), rbit(), z, ev(3'd1, 0, 0, 0, 0, 0, z, z, 0));
      m_count++;
    end else if (k == KL || k == KS) begin
      isl = (k == KL);
      step("exec mem", 4'($urandom), rbit(), rbit(), ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      w = 0;
      do begin
        rdy = (mwait < 0) ? (w >= 20 || $urandom_range(0, 2) != 0) : (w >= mwait);
        step("mem", 4'($urandom), rdy, rbit(), ev(3'd0, 0, isl, !isl, 0, 0, 0, 0, 0));
        t_mcyc++;
        w++;
      end while (!rdy);
      if (isl) begin
        step("wb load", 4'($urandom), rbit(), rbit(), ev(3'd0, 1, 0, 0, 1, 0, 0, 0, 0));
      end
      m_count++;
    end else if (k == KI) begin
`ifdef ILLEGAL_TRAP_EN
      m_ill = 1'b1;
`else
      m_count++;
`endif
    end else begin
      m_count++;  // JMP, NOP, HALT
    end
  endtask

  initial begin
    vec_t tbl [0:10];
    int   c0;
    logic [3:0] legal [0:9];
    logic [3:0] ill [0:4];
    logic [3:0] op;

    tbl[0]  = '{4'h0, 1'b0, 4, 3'd0, 1'b0};
    tbl[1]  = '{4'h1, 1'b0, 4, 3'd1, 1'b0};
    tbl[2]  = '{4'h2, 1'b0, 4, 3'd2, 1'b0};
    tbl[3]  = '{4'h3, 1'b0, 4, 3'd3, 1'b0};
    tbl[4]  = '{4'h4, 1'b0, 4, 3'd4, 1'b0};
    tbl[5]  = '{4'h8, 1'b0, 5, 3'd0, 1'b0};
    tbl[6]  = '{4'h9, 1'b0, 4, 3'd0, 1'b0};
    tbl[7]  = '{4'hA, 1'b1, 3, 3'd1, 1'b1};
    tbl[8]  = '{4'hA, 1'b0, 3, 3'd1, 1'b0};
    tbl[9]  = '{4'hB, 1'b0, 2, 3'd0, 1'b1};
    tbl[10] = '{4'hE, 1'b0, 2, 3'd0, 1'b0};
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE};
    ill   = '{4'h5, 4'h6, 4'h7, 4'hC, 4'hD};

    do_reset();

    // Each instruction alone with memory always ready.
    for (int i = 0; i <= 10; i++) begin
      run_instr(tbl[i].op, tbl[i].z, 0, 0);
      chk($sformatf("tbl[%0d] len", i), 32'(t_len), 32'(tbl[i].len));
      chk($sformatf("tbl[%0d] alu", i), 32'(t_alu), 32'(tbl[i].alu));
      chk($sformatf("tbl[%0d] pcsrc", i), 32'(t_pcs), 32'(tbl[i].pcs));
      #1;
      chk($sformatf("tbl[%0d] retired", i), 32'(instr_count), 32'(i + 1));
    end

    // LOAD with three memory wait cycles.
    do_reset();
    run_instr(4'h8, 1'b0, 0, 3);
    chk("load memread cycles", 32'(t_mcyc), 32'd4);
    chk("load len", 32'(t_len), 32'd8);

    // Opcode 0101.
    do_reset();
    run_instr(4'h5, 1'b0, 1, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step("trap", 4'($urandom), rbit(), rbit(), 11'd0);
    chk("trap count", 32'(instr_count), 32'd0);
`else
    chk("illegal as nop len", 32'(t_len), 32'd3);
    step("after illegal", 4'($urandom), 1'b0, rbit(), ev(3'd0, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("illegal as nop count", 32'(instr_count), 32'd1);
`endif

    // HALT stays halted.
    do_reset();
    run_instr(4'h0, 1'b0, 0, 0);
    run_instr(4'hF, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) step("halt", 4'($urandom), rbit(), rbit(), ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("halt count", 32'(instr_count), 32'd2);

    // Reset while a STORE waits in MEM.
    do_reset();
    run_instr(4'h1, 1'b0, 0, 0);
    step("st fetch", 4'h3, 1'b1, 1'b0, ev(3'd0, 0, 1, 0, 0, 1, 1, 0, 0));
    step("st decode", 4'h9, 1'b0, 1'b0, 11'd0);
    step("st exec", 4'h2, 1'b1, 1'b1, 11'd0);
    step("st mem", 4'h2, 1'b0, 1'b0, ev(3'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid-mem reset outs", 32'(outs()), 32'd0);
    chk("mid-mem reset count", 32'(instr_count), 32'd0);
    do_reset();

    // Counter wrap on the 4-bit copy.
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(4'hE, 1'b0, -1, 0);
    #1;
    chk("count4 before wrap", 32'(d4_count), 32'd15);
    run_instr(4'hE, 1'b0, -1, 0);
    #1;
    chk("count4 wrapped", 32'(d4_count), 32'd0);
    chk("count16 no wrap", 32'(instr_count), 32'd16);

    // Random program with random memory latency.
    do_reset();
    for (int i = 0; i < 200; i++) begin
`ifdef ILLEGAL_TRAP_EN
      op = legal[$urandom_range(0, 9)];
`else
      op = ($urandom_range(0, 7) == 0) ? ill[$urandom_range(0, 4)] : legal[$urandom_range(0, 9)];
`endif
      run_instr(op, rbit(), -1, -1);
    end
    c0 = int'(m_count);
    run_instr(4'hF, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) step("rand halt", 4'($urandom), rbit(), rbit(), ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("rand final count", 32'(instr_count), 32'(c0 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
